// File: rtl/sh_wdt_gen_pkg.sv
// Shared types and constants for the sh_wdt_gen watchdog/interval timer.
// Includes the CSR layout, the bus write keys and the prescaler tap table.
package sh_wdt_gen_pkg;

    typedef enum logic [1:0] {
        WDTG_MODE_INTERVAL  = 2'b00,
        WDTG_MODE_WATCHDOG  = 2'b01,
        WDTG_MODE_WINDOW    = 2'b10,
        WDTG_MODE_WATCHDOG2 = 2'b11
    } WDTG_MODE_t;

    typedef struct packed {
        logic       ovf;
        logic       wovf;
        logic       early;
        logic [3:0] rsv;
        logic       lock;
        logic       rsts;
        logic       rste;
        WDTG_MODE_t mode;
        logic       tme;
        logic [2:0] cks;
    } WDTG_CSR_t;

    localparam logic [7:0] WDTG_KEY_CSR = 8'hA5;
    localparam logic [7:0] WDTG_KEY_CNT = 8'h5A;
    localparam int         WDTG_PRE_W   = 13;

    // Entry [n] is log2 of the divider selected by CKS=n.
    localparam logic [7:0][3:0] WDTG_DIV_LOG2 = {4'd13, 4'd12, 4'd10, 4'd9,
                                                 4'd8,  4'd7,  4'd6,  4'd1};

    function automatic logic [WDTG_PRE_W-1:0] wdtg_pre_mask(input logic [2:0] cks);
        return (WDTG_PRE_W'(1'b1) << WDTG_DIV_LOG2[cks]) - WDTG_PRE_W'(1'b1);
    endfunction

endpackage

// File: rtl/sh_wdt_gen_pulse.sv
// Loadable pulse stretcher: busy_o rises on the edge after start_i and stays
// high for exactly WIDTH clock cycles; a new start restarts the full width.
module sh_wdt_pulse #(
    parameter int WIDTH = 128
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Next-state for the remaining-cycle counter and busy flag.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1'b1);
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/sh_wdt_gen.sv
// Watchdog / interval timer on the internal peripheral bus: prescaler, CNT_W-bit
// up-counter, interval/watchdog/window modes, keyed writes and a sticky config lock.
module sh_wdt_gen
    import sh_wdt_gen_pkg::*;
#(
    parameter int          CNT_W     = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFE80,
    parameter int          OVF_PULSE = 128,
    parameter int          RES_PULSE = 512
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    output logic        ITI_IRQ,
    output logic        WDTOVF_N,
    output logic        RES_REQ,
    output logic        RES_TYPE
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    WDTG_CSR_t              csr_q, csr_d, wr_csr_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d, win_q, win_d;
    logic [WDTG_PRE_W-1:0]  pre_q, pre_d, pre_mask_s;
    logic [31:0]            do_q, do_d, rd_data_s, off_s;
    logic [1:0]             word_s;
    logic                   rtype_q, rtype_d;
    logic act_s, wr_s, rd_s, csr_wr_s, cnt_wr_s, win_wr_s;
    logic tick_s, wd_mode_s, wrap_s, early_s, action_s;
    logic ovf_busy_s, res_busy_s, unused_s;

    assign off_s    = IBUS_A - BASE_ADDR;
    assign word_s   = off_s[3:2];
    assign act_s    = (IBUS_A >= BASE_ADDR) && (IBUS_A <= (BASE_ADDR + 32'h0000000B));
    assign wr_s     = CE_R & IBUS_REQ & IBUS_WE & act_s;
    assign rd_s     = CE_F & IBUS_REQ & ~IBUS_WE & act_s;
    assign csr_wr_s = wr_s & (word_s == 2'd0) & (IBUS_DI[31:24] == WDTG_KEY_CSR);
    assign cnt_wr_s = wr_s & (word_s == 2'd1) & (IBUS_DI[31:24] == WDTG_KEY_CNT);
    assign win_wr_s = wr_s & (word_s == 2'd2) & (IBUS_DI[31:24] == WDTG_KEY_CNT);
    assign wr_csr_s = WDTG_CSR_t'(IBUS_DI[15:0]);

    assign pre_mask_s = wdtg_pre_mask(csr_q.cks);
    assign tick_s     = CE_R & csr_q.tme & ((pre_q & pre_mask_s) == pre_mask_s);
    assign wd_mode_s  = (csr_q.mode != WDTG_MODE_INTERVAL);
    // A same-cycle CNT write suppresses the increment, so it also suppresses the wrap.
    assign wrap_s     = tick_s & ~cnt_wr_s & (cnt_q == CNT_MAX);
    assign early_s    = cnt_wr_s & (csr_q.mode == WDTG_MODE_WINDOW) & (cnt_q < win_q);
    assign action_s   = (wrap_s & wd_mode_s) | early_s;

    assign unused_s = ^{IBUS_DI[23:16], off_s[31:4], off_s[1:0], wr_csr_s.rsv};

    // Next-state for counter, window, prescaler and CSR.
    always_comb begin
        csr_d   = csr_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        pre_d   = pre_q;
        rtype_d = rtype_q;

        if (!csr_q.tme) begin
            pre_d = '0;
        end else if (CE_R) begin
            pre_d = pre_q + WDTG_PRE_W'(1'b1);
        end else begin
            pre_d = pre_q;
        end

        if (cnt_wr_s) begin
            cnt_d = IBUS_DI[CNT_W-1:0];
        end else if (tick_s) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end

        if (win_wr_s) begin
            win_d = IBUS_DI[CNT_W-1:0];
        end else begin
            win_d = win_q;
        end

        // A CSR write owns TME outright; otherwise a watchdog overflow stops the timer.
        if (csr_wr_s) begin
            csr_d.tme   = wr_csr_s.tme;
            csr_d.ovf   = csr_q.ovf & wr_csr_s.ovf;
            csr_d.wovf  = csr_q.wovf & wr_csr_s.wovf;
            csr_d.early = csr_q.early & wr_csr_s.early;
            if (!csr_q.lock) begin
                csr_d.cks  = wr_csr_s.cks;
                csr_d.mode = wr_csr_s.mode;
                csr_d.rste = wr_csr_s.rste;
                csr_d.rsts = wr_csr_s.rsts;
                csr_d.lock = wr_csr_s.lock;
            end else begin
                csr_d.lock = csr_q.lock;
            end
        end else if (wrap_s & wd_mode_s) begin
            csr_d.tme = 1'b0;
        end else begin
            csr_d.tme = csr_q.tme;
        end

        csr_d.ovf   = csr_d.ovf | (wrap_s & ~wd_mode_s);
        csr_d.wovf  = csr_d.wovf | (wrap_s & wd_mode_s);
        csr_d.early = csr_d.early | early_s;
        csr_d.rsv   = 4'b0000;

        if (action_s & csr_q.rste) begin
            rtype_d = csr_q.rsts;
        end else begin
            rtype_d = rtype_q;
        end
    end

    // Read-data mux and falling-phase capture.
    always_comb begin
        case (word_s)
            2'd0:    rd_data_s = {16'h0000, csr_q};
            2'd1:    rd_data_s = 32'(cnt_q);
            2'd2:    rd_data_s = 32'(win_q);
            default: rd_data_s = 32'h00000000;
        endcase
        if (rd_s) begin
            do_d = rd_data_s;
        end else if (CE_F) begin
            do_d = 32'h00000000;
        end else begin
            do_d = do_q;
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            csr_q   <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            pre_q   <= '0;
            do_q    <= 32'h00000000;
            rtype_q <= 1'b0;
        end else begin
            csr_q   <= csr_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            pre_q   <= pre_d;
            do_q    <= do_d;
            rtype_q <= rtype_d;
        end
    end

    sh_wdt_pulse #(.WIDTH(OVF_PULSE)) u_ovf_pulse (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (action_s),
        .busy_o  (ovf_busy_s)
    );

    sh_wdt_pulse #(.WIDTH(RES_PULSE)) u_res_pulse (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (action_s & csr_q.rste),
        .busy_o  (res_busy_s)
    );

    assign IBUS_DO   = do_q;
    assign IBUS_BUSY = 1'b0;
    assign IBUS_ACT  = act_s;
    assign ITI_IRQ   = csr_q.ovf;
    assign WDTOVF_N  = ~ovf_busy_s;
    assign RES_REQ   = res_busy_s;
    assign RES_TYPE  = rtype_q;

endmodule

// File: tb/tb_sh_wdt_gen.sv
// Self-checking bench for sh_wdt_gen: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the timer.
module tb_sh_wdt_gen;
    localparam logic [31:0] BASE   = 32'hFFFFFE80;
    localparam logic [31:0] BASE16 = 32'hFFFFFF00;
    localparam int OVF_P = 128;
    localparam int RES_P = 512;

    logic        CLK = 1'b0;
    logic        RST, CE_R, CE_F, IBUS_WE, IBUS_REQ;
    logic [31:0] IBUS_A, IBUS_DI;
    logic [31:0] do8, do16;
    logic busy8, busy16, act8, act16, iti8, iti16, ovfn8, ovfn16, rr8, rr16, rt8, rt16;

    always #5 CLK = ~CLK;

    sh_wdt_gen #(.CNT_W(8), .BASE_ADDR(BASE), .OVF_PULSE(OVF_P), .RES_PULSE(RES_P)) dut8 (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI),
        .IBUS_DO(do8), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(busy8),
        .IBUS_ACT(act8), .ITI_IRQ(iti8), .WDTOVF_N(ovfn8), .RES_REQ(rr8), .RES_TYPE(rt8));

    sh_wdt_gen #(.CNT_W(16), .BASE_ADDR(BASE16), .OVF_PULSE(OVF_P), .RES_PULSE(RES_P)) dut16 (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI),
        .IBUS_DO(do16), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(busy16),
        .IBUS_ACT(act16), .ITI_IRQ(iti16), .WDTOVF_N(ovfn16), .RES_REQ(rr16), .RES_TYPE(rt16));

    int total = 0;
    int bad   = 0;

    // Reference model state for the 8-bit instance.
    int m_cnt, m_win, m_pre, m_ovf_left, m_res_left;
    bit [2:0] m_cks;
    bit [1:0] m_mode;
    bit m_tme, m_rste, m_rsts, m_lock, m_early, m_wovf, m_ovf, m_rtype;
    bit [31:0] m_do;
    int div_log2 [8] = '{1, 6, 7, 8, 9, 10, 12, 13};

    logic [31:0] d;
    int lo, hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_act(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd11);
    endfunction

    function automatic bit [31:0] m_csr();
        return (32'(m_ovf) << 15) | (32'(m_wovf) << 14) | (32'(m_early) << 13) |
               (32'(m_lock) << 8) | (32'(m_rsts) << 7) | (32'(m_rste) << 6) |
               (32'(m_mode) << 4) | (32'(m_tme) << 3) | 32'(m_cks);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic m_clock();
        bit act, csr_wr, cnt_wr, win_wr, tick, wd, wrap, early, action;
        int word;
        bit [31:0] rdv;
        if (RST) begin
            m_cnt = 0; m_win = 0; m_pre = 0; m_ovf_left = 0; m_res_left = 0;
            m_cks = 0; m_mode = 0; m_tme = 0; m_rste = 0; m_rsts = 0; m_lock = 0;
            m_early = 0; m_wovf = 0; m_ovf = 0; m_rtype = 0; m_do = 0;
            return;
        end
        act  = m_act(IBUS_A);
        word = int'((IBUS_A - BASE) >> 2);
        if (CE_F) begin
            rdv = 0;
            if (IBUS_REQ && !IBUS_WE && act) begin
                case (word)
                    0: rdv = m_csr();
                    1: rdv = 32'(m_cnt);
                    2: rdv = 32'(m_win);
                    default: rdv = 0;
                endcase
            end
            m_do = rdv;
        end
        csr_wr = CE_R && IBUS_REQ && IBUS_WE && act && word == 0 && IBUS_DI[31:24] == 8'hA5;
        cnt_wr = CE_R && IBUS_REQ && IBUS_WE && act && word == 1 && IBUS_DI[31:24] == 8'h5A;
        win_wr = CE_R && IBUS_REQ && IBUS_WE && act && word == 2 && IBUS_DI[31:24] == 8'h5A;
        tick   = CE_R && m_tme && ((m_pre + 1) % (1 << div_log2[m_cks]) == 0);
        wd     = (m_mode != 0);
        wrap   = tick && !cnt_wr && m_cnt == 255;
        early  = cnt_wr && m_mode == 2 && m_cnt < m_win;
        action = (wrap && wd) || early;

        if (m_ovf_left > 0) m_ovf_left--;
        if (m_res_left > 0) m_res_left--;
        if (action) begin
            m_ovf_left = OVF_P;
            if (m_rste) begin
                m_res_left = RES_P;
                m_rtype = m_rsts;
            end
        end

        if (!m_tme) m_pre = 0;
        else if (CE_R) m_pre = (m_pre + 1) % 8192;
        if (cnt_wr) m_cnt = int'(IBUS_DI[7:0]);
        else if (tick) m_cnt = (m_cnt + 1) % 256;
        if (win_wr) m_win = int'(IBUS_DI[7:0]);

        if (csr_wr) begin
            if (!IBUS_DI[15]) m_ovf = 0;
            if (!IBUS_DI[14]) m_wovf = 0;
            if (!IBUS_DI[13]) m_early = 0;
            m_tme = IBUS_DI[3];
            if (!m_lock) begin
                m_cks = IBUS_DI[2:0]; m_mode = IBUS_DI[5:4];
                m_rste = IBUS_DI[6]; m_rsts = IBUS_DI[7]; m_lock = IBUS_DI[8];
            end
        end else if (wrap && wd) begin
            m_tme = 0;
        end
        if (wrap && !wd) m_ovf = 1;
        if (wrap && wd) m_wovf = 1;
        if (early) m_early = 1;
    endtask

    task automatic cyc();
        m_clock();
        @(posedge CLK);
        #1;
        chk("wdtovf_n", 32'(ovfn8), 32'(m_ovf_left == 0));
        chk("res_req", 32'(rr8), 32'(m_res_left > 0));
        chk("res_type", 32'(rt8), 32'(m_rtype));
        chk("iti_irq", 32'(iti8), 32'(m_ovf));
        chk("ibus_do", do8, m_do);
        chk("ibus_act", 32'(act8), 32'(m_act(IBUS_A)));
        chk("ibus_busy", 32'(busy8), 32'd0);
    endtask

    task automatic idle();
        RST = 1'b0; CE_R = 1'b0; CE_F = 1'b0; IBUS_REQ = 1'b0; IBUS_WE = 1'b0;
        IBUS_A = 32'h0; IBUS_DI = 32'h0;
    endtask

    task automatic do_reset();
        RST = 1'b1; cyc(); RST = 1'b0;
    endtask

    task automatic wr(input logic [31:0] base, input int off, input logic [7:0] key,
                      input logic [23:0] pay);
        IBUS_REQ = 1'b1; IBUS_WE = 1'b1; IBUS_A = base + 32'(off * 4);
        IBUS_DI = {key, pay}; CE_R = 1'b1;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [31:0] base, input int off, output logic [31:0] q);
        IBUS_REQ = 1'b1; IBUS_WE = 1'b0; IBUS_A = base + 32'(off * 4); CE_F = 1'b1;
        cyc();
        q = (base == BASE) ? do8 : do16;
        idle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            CE_R = 1'b1;
            cyc();
        end
        CE_R = 1'b0;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [7:0]  key;
        logic [23:0] pay;
        idle();
        do_reset();
        rd(BASE, 0, d); chk("rst_csr", d, 32'h0);
        rd(BASE, 1, d); chk("rst_cnt", d, 32'h0);
        rd(BASE, 2, d); chk("rst_win", d, 32'h0);
        chk("rst_wdtovf_n", 32'(ovfn8), 32'd1);

        // interval mode wrap from FE
        wr(BASE, 1, 8'h5A, 24'h0000FE);
        wr(BASE, 0, 8'hA5, 24'h000008);
        run(3); chk("int_irq_early", 32'(iti8), 32'd0);
        run(1); chk("int_irq", 32'(iti8), 32'd1);
        rd(BASE, 1, d); chk("int_cnt_wrap", d, 32'h0);
        rd(BASE, 0, d); chk("int_csr", d, 32'h8008);
        run(2);
        rd(BASE, 1, d); chk("int_cnt_cont", d, 32'h1);
        wr(BASE, 0, 8'hA5, 24'h000008); chk("int_ovf_clear", 32'(iti8), 32'd0);

        // keys and lock
        do_reset();
        wr(BASE, 0, 8'h5A, 24'h000018);
        rd(BASE, 0, d); chk("key_csr", d, 32'h0);
        wr(BASE, 1, 8'h5A, 24'h000033);
        wr(BASE, 1, 8'hA5, 24'h000077);
        rd(BASE, 1, d); chk("key_cnt", d, 32'h33);
        wr(BASE, 2, 8'hA5, 24'h000044);
        rd(BASE, 2, d); chk("key_win", d, 32'h0);
        wr(BASE, 0, 8'hA5, 24'h000100);
        wr(BASE, 0, 8'hA5, 24'h000018);
        rd(BASE, 0, d); chk("lock_mode", d, 32'h108);
        rd(BASE, 3, d); chk("unmapped", d, 32'h0);

        // same-cycle priorities
        do_reset();
        wr(BASE, 1, 8'h5A, 24'h0000FF);
        wr(BASE, 0, 8'hA5, 24'h000008);
        run(1);
        wr(BASE, 1, 8'h5A, 24'h000010);
        chk("prio_no_ovf", 32'(iti8), 32'd0);
        rd(BASE, 1, d); chk("prio_cnt", d, 32'h10);
        wr(BASE, 1, 8'h5A, 24'h0000FF);
        wr(BASE, 0, 8'hA5, 24'h000008);
        chk("prio_set_wins", 32'(iti8), 32'd1);
        rd(BASE, 0, d); chk("prio_csr", d, 32'h8008);

        // watchdog overflow with reset request
        do_reset();
        wr(BASE, 1, 8'h5A, 24'h0000FF);
        wr(BASE, 0, 8'hA5, 24'h0000D8);
        run(2);
        chk("wd_ovf_low", 32'(ovfn8), 32'd0);
        chk("wd_res_type", 32'(rt8), 32'd1);
        lo = 0; hi = 0;
        for (int i = 0; i < 600; i++) begin
            if (!ovfn8) lo++;
            if (rr8) hi++;
            cyc();
        end
        chk("wd_ovf_len", 32'(lo), 32'(OVF_P));
        chk("wd_res_len", 32'(hi), 32'(RES_P));
        rd(BASE, 0, d); chk("wd_csr", d, 32'h40D0);

        // reset during the overflow pulse
        do_reset();
        wr(BASE, 1, 8'h5A, 24'h0000FF);
        wr(BASE, 0, 8'hA5, 24'h0000D8);
        run(2);
        wait_n(20);
        RST = 1'b1; cyc(); RST = 1'b0;
        chk("rstmid_ovfn", 32'(ovfn8), 32'd1);
        chk("rstmid_res", 32'(rr8), 32'd0);
        rd(BASE, 0, d); chk("rstmid_csr", d, 32'h0);

        // window mode: early kick, then legal kick
        do_reset();
        wr(BASE, 2, 8'h5A, 24'h000080);
        wr(BASE, 1, 8'h5A, 24'h000040);
        wr(BASE, 0, 8'hA5, 24'h000028);
        wr(BASE, 1, 8'h5A, 24'h000030);
        chk("win_early_pulse", 32'(ovfn8), 32'd0);
        chk("win_no_res", 32'(rr8), 32'd0);
        rd(BASE, 0, d); chk("win_early_csr", d, 32'h2028);
        rd(BASE, 1, d); chk("win_early_cnt", d, 32'h30);
        wr(BASE, 0, 8'hA5, 24'h000020);
        wait_n(130);
        wr(BASE, 2, 8'h5A, 24'h000000);
        wr(BASE, 1, 8'h5A, 24'h000090);
        wr(BASE, 2, 8'h5A, 24'h000080);
        wr(BASE, 1, 8'h5A, 24'h000010);
        chk("win_ok_nopulse", 32'(ovfn8), 32'd1);
        rd(BASE, 1, d); chk("win_ok_cnt", d, 32'h10);
        rd(BASE, 0, d); chk("win_ok_csr", d, 32'h20);

        // 16-bit counter wraps at FFFF
        do_reset();
        wr(BASE16, 1, 8'h5A, 24'h00FFFE);
        wr(BASE16, 0, 8'hA5, 24'h000008);
        run(3); chk("w16_irq_early", 32'(iti16), 32'd0);
        run(1); chk("w16_irq", 32'(iti16), 32'd1);
        rd(BASE16, 1, d); chk("w16_cnt", d, 32'h0);
        rd(BASE16, 0, d); chk("w16_csr", d, 32'h8008);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RST      = ($urandom_range(0, 299) == 0);
            CE_R     = 1'($urandom_range(0, 1));
            CE_F     = 1'($urandom_range(0, 1));
            IBUS_REQ = ($urandom_range(0, 3) != 0);
            IBUS_WE  = 1'($urandom_range(0, 1));
            IBUS_A   = ($urandom_range(0, 9) != 0) ? BASE + 32'($urandom_range(0, 11))
                                                   : 32'($urandom);
            case ($urandom_range(0, 4))
                0, 1:    key = 8'hA5;
                2, 3:    key = 8'h5A;
                default: key = 8'($urandom);
            endcase
            pay = 24'($urandom);
            pay[8] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) pay[2:1] = 2'b00;
            if ($urandom_range(0, 1) != 0) pay[7:5] = 3'b111;
            IBUS_DI = {key, pay};
            cyc();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
